// File: rtl/hex_scroll_pkg.sv
// ---------------------------------------------------------------------------
// hex_scroll_pkg
//
// Shared types and helpers for the seven-segment message scroller.
//   state_t      : scroller FSM states (IDLE / FETCH / SHOW)
//   seg_t        : one seven-segment digit, active-low, bit order gfedcba
//   SEG_BLANK    : all segments off
//   char_to_seg  : ASCII code to segment pattern; unknown codes are blank
// ---------------------------------------------------------------------------
package hex_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Only the glyphs that render legibly on seven segments are mapped.
    // Letters are case-exact: 'A' and 'a' are different codes, and only
    // the form that looks right on the display is recognised.
    function automatic seg_t char_to_seg(input logic [7:0] ch);
        case (ch)
            8'h30:   return 7'b1000000;  // 0
            8'h31:   return 7'b1111001;  // 1
            8'h32:   return 7'b0100100;  // 2
            8'h33:   return 7'b0110000;  // 3
            8'h34:   return 7'b0011001;  // 4
            8'h35:   return 7'b0010010;  // 5
            8'h36:   return 7'b0000010;  // 6
            8'h37:   return 7'b1111000;  // 7
            8'h38:   return 7'b0000000;  // 8
            8'h39:   return 7'b0010000;  // 9
            8'h41:   return 7'b0001000;  // A
            8'h62:   return 7'b0000011;  // b
            8'h43:   return 7'b1000110;  // C
            8'h64:   return 7'b0100001;  // d
            8'h45:   return 7'b0000110;  // E
            8'h46:   return 7'b0001110;  // F
            8'h67:   return 7'b0010000;  // g
            8'h68:   return 7'b0001011;  // h
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//
// Combinational ASCII to seven-segment decoder for a single digit.
//   ch   in  8  ASCII character
//   seg  out 7  active-low segments, gfedcba
// ---------------------------------------------------------------------------
module seg7_decode
    import hex_scroll_pkg::*;
(
    input  logic [7:0] ch,
    output seg_t       seg
);

    assign seg = char_to_seg(ch);

endmodule

// File: rtl/hex_scroll_display.sv
// ---------------------------------------------------------------------------
// hex_scroll_display
//
// Multi-digit seven-segment message scroller. A DIGITS-wide window of an
// MSG_LEN-character message is read from a synchronous character memory into
// a shadow buffer, and the whole window is decoded into HEX on a single edge
// so the display never shows a half-updated frame.
//
// Ports:
//   CLOCK     in   1          clock, rising edge
//   RESETn    in   1          synchronous active-low reset
//   step_en   in   1          tick advancing the step divider
//   run       in   1          1 = scroll, 0 = freeze
//   dir       in   1          0 = scroll left (offset+1), 1 = right (offset-1)
//   mem_addr  out  ADDR_W     character memory read address
//   mem_data  in   8          character, valid the cycle after mem_addr
//   HEX       out  DIGITS*7   active-low segments, digit 0 rightmost
//   LEDR      out  10         {2'b0, character at offset}
//   busy      out  1          frame fetch in progress
//
// Optional feature macro: HEX_SCROLL_BLINK_EN
//   When defined, step_en pulses while frozen (SHOW, run=0) toggle a blink
//   flag that blanks HEX; run=1 or reset clears it.
// ---------------------------------------------------------------------------
module hex_scroll_display
    import hex_scroll_pkg::*;
#(
    parameter int DIGITS  = 6,
    parameter int MSG_LEN = 16,
    parameter int ADDR_W  = 5,
    parameter int DIV     = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESETn,
    input  logic                  step_en,
    input  logic                  run,
    input  logic                  dir,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [7:0]            mem_data,
    output logic [DIGITS*7-1:0]   HEX,
    output logic [9:0]            LEDR,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DIV - 1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_W-1:0]     offset;
    logic [ADDR_W-1:0]     next_offset;
    logic [CNT_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      fetch_idx;
    logic [7:0]            shadow     [DIGITS];
    logic [7:0]            frame_char [DIGITS];
    seg_t                  frame_seg  [DIGITS];
    logic [DIGITS*7-1:0]   frame_hex;
    logic [DIGITS*7-1:0]   hex_reg;
    logic                  step_fire;
    logic                  fetch_done;

    // Address arithmetic wraps by comparison instead of a modulo so no
    // divider is inferred for non-power-of-two message lengths.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_dec(input logic [ADDR_W-1:0] a);
        return (a == '0) ? LAST_ADDR : a - 1'b1;
    endfunction

    // Step and fetch-completion qualifiers shared by the FSM and datapath.
    always_comb begin
        step_fire   = (state == SHOW) && step_en && run && (div_cnt == LAST_CNT);
        fetch_done  = (state == FETCH) && (fetch_idx == LAST_IDX);
        next_offset = dir ? wrap_dec(offset) : wrap_inc(offset);
    end

    // State register.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the busy flag.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (fetch_done) begin
                    next_state = SHOW;
                end
            end
            SHOW: begin
                if (step_fire) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The frame being committed: slot 0 is the last character to arrive and
    // is taken straight from the memory bus so it can be decoded on the same
    // edge it would have been captured.
    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_bus
                assign frame_char[k] = mem_data;
            end else begin : g_shadow
                assign frame_char[k] = shadow[k];
            end
            seg7_decode u_decode (
                .ch  (frame_char[k]),
                .seg (frame_seg[k])
            );
            assign frame_hex[7*k +: 7] = frame_seg[k];
        end
    endgenerate

    // Datapath: issue addresses and capture characters during FETCH, commit
    // the frame on the final FETCH edge, and run the step divider in SHOW.
    // Issue i's character returns during FETCH cycle i+1 and lands in slot
    // DIGITS-1-i, i.e. slot DIGITS-fetch_idx.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            offset    <= '0;
            div_cnt   <= '0;
            fetch_idx <= '0;
            mem_addr  <= '0;
            hex_reg   <= {DIGITS{SEG_BLANK}};
            LEDR      <= '0;
            for (int s = 0; s < DIGITS; s++) begin
                shadow[s] <= 8'h20;
            end
        end else begin
            case (state)
                IDLE: begin
                    fetch_idx <= '0;
                    mem_addr  <= offset;
                end
                FETCH: begin
                    mem_addr  <= wrap_inc(mem_addr);
                    fetch_idx <= fetch_idx + 1'b1;
                    for (int s = 0; s < DIGITS; s++) begin
                        if (fetch_idx == IDX_W'(DIGITS - s)) begin
                            shadow[s] <= mem_data;
                        end
                    end
                    if (fetch_done) begin
                        fetch_idx <= '0;
                        hex_reg   <= frame_hex;
                        LEDR      <= {2'b00, frame_char[DIGITS-1]};
                    end
                end
                SHOW: begin
                    if (step_en && run) begin
                        if (div_cnt == LAST_CNT) begin
                            div_cnt   <= '0;
                            offset    <= next_offset;
                            mem_addr  <= next_offset;
                            fetch_idx <= '0;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    fetch_idx <= '0;
                end
            endcase
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    logic blink;

    // Blink flag: toggled by ticks while frozen, cleared as soon as scrolling
    // resumes. It only masks HEX; the committed frame and LEDR are untouched.
    always_ff @(posedge CLOCK) begin
        if (!RESETn) begin
            blink <= 1'b0;
        end else if (run) begin
            blink <= 1'b0;
        end else if ((state == SHOW) && step_en) begin
            blink <= ~blink;
        end
    end

    assign HEX = blink ? {DIGITS{SEG_BLANK}} : hex_reg;
`else
    assign HEX = hex_reg;
`endif

endmodule

// File: doc/hex_scroll_display.md
# hex_scroll_display

Parametrised multi-digit seven-segment message scroller. It reads an ASCII message from a synchronous character memory and shows a DIGITS-wide window of it on the HEX displays. The window scrolls left or right on divided step ticks and wraps around the message end. It sits between a board-level character memory and the HEX/LEDR outputs, and extends the single-digit counter-plus-decoder display to N digits with a handshake-free, tear-free frame fetch.

## Interface
- DIGITS, 6: number of HEX digits driven (1..8).
- MSG_LEN, 16: message length in characters (≥1); addresses 0..MSG_LEN-1.
- ADDR_W, 5: character-memory address width; must satisfy 2**ADDR_W ≥ MSG_LEN.
- DIV, 4: step_en pulses per scroll step (≥1).

Ports:
- CLOCK  in  1  sole clock, rising edge.
- RESETn  in  1  synchronous, active-low reset.
- step_en  in  1  one-cycle tick that advances the step divider.
- run  in  1  1 = scroll, 0 = freeze the window.
- dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset−1).
- mem_addr  out  ADDR_W  character-memory read address.
- mem_data  in  8  ASCII character; valid on the cycle after mem_addr.
- HEX  out  DIGITS*7  active-low segments; digit k at [7k+6:7k]; digit 0 is rightmost.
- LEDR  out  10  {2'b0, character at offset}.
- busy  out  1  high while a frame fetch is in progress.

## Operation
- FSM states: IDLE, FETCH, SHOW.
  - IDLE → FETCH unconditionally.
  - FETCH → SHOW after the last capture.
  - SHOW → FETCH on a scroll step.
- FETCH takes DIGITS+1 cycles.
  - Issue cycle i (0..DIGITS-1): mem_addr = (offset+i) mod MSG_LEN. Compute this by compare-and-subtract, not `%`.
  - Capture: the character returned for issue i lands in shadow slot DIGITS-1-i one cycle later. The leftmost digit shows offset.
  - On the final FETCH edge, shadow is decoded into HEX and the offset character into LEDR, all at once. HEX never shows a partial frame.
- SHOW:
  - Each step_en with run=1 increments div_cnt.
  - When div_cnt = DIV-1 and step_en=1: div_cnt ← 0, update offset per dir (sampled that cycle), enter FETCH.
  - run=0 holds div_cnt and offset.
- Offset wrap: MSG_LEN-1 + 1 → 0; 0 − 1 → MSG_LEN-1. With MSG_LEN < DIGITS, the window repeats characters modulo MSG_LEN.
- step_en during IDLE or FETCH is ignored and not counted.
- Decode (active-low, gfedcba):
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, g=0010000, h=0001011.
  - '0'..'9' use standard patterns ('0'=1000000, '1'=1111001).
  - Space and all other codes = 1111111.

## Timing
- Reset values: state IDLE, offset 0, div_cnt 0, mem_addr 0, HEX all ones (blank), LEDR 0, busy 0, shadow all 0x20.
- busy = (state == FETCH), combinational.
- First frame: HEX is valid DIGITS+2 rising edges after the first edge with RESETn=1.
- Step latency: from the edge sampling the terminal step_en to the new HEX is DIGITS+2 edges.
- Reset mid-FETCH aborts the fetch and discards the shadow. HEX blanks on that edge, and the fetch restarts at offset 0.

## Configuration
- HEX_SCROLL_BLINK_EN defined:
  - In SHOW with run=0, each step_en toggles a blink flag. While the flag is 1, HEX is forced to all ones.
  - The flag clears on reset or when run=1. LEDR is unaffected.
- Undefined: no blink flag; HEX holds steady while frozen.

## Structure
- Package hex_scroll_pkg:
  - state enum (IDLE/FETCH/SHOW).
  - seg_t typedef (logic [6:0]).
  - SEG_BLANK constant.
  - ASCII-to-segment function char_to_seg.
- Sub-module seg7_decode: combinational wrapper around char_to_seg, instantiated DIGITS times under generate.

## Test plan
Bench setup: DIGITS=4, MSG_LEN=6, DIV=2, memory = "AbCdEF", digits listed left→right.
1. Hold RESETn=0 for 3 edges, then release → HEX blank and busy=0 during reset. busy=1 for 5 cycles. HEX = A b C d after 6 edges. LEDR=65.
2. run=1, dir=0, two step_en pulses → one fetch, then HEX = b C d E, LEDR=98. A single pulse alone changes nothing.
3. Step left from offset 5 → HEX = F A b C. Next step → A b C d (wrap to 0).
4. dir=1 at offset 0, one step → offset 5, HEX = F A b C, LEDR=70.
5. step_en pulses during FETCH and with run=0 → offset unchanged. With BLINK_EN, HEX alternates blank / F A b C per pulse while run=0.
6. RESETn=0 on the 2nd FETCH cycle → HEX blank next edge. After release, refetch from 0 yields A b C d. Replacing 'C' with '?' shows 1111111 in that digit.
